// File: rtl/hsv_colour_bbox_pkg.sv
// Shared widths, constants and FSM state type for the HSV colour
// classification / bounding-box stage.
package hsv_pkg;

    localparam int unsigned H_W     = 9;
    localparam int unsigned SV_W    = 8;
    localparam int unsigned COORD_W = 11;
    localparam int unsigned CNT_W   = 20;

    localparam logic [H_W-1:0] HUE_MAX = 9'd359;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        PUBLISH = 2'd2
    } state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/hsv_colour_bbox_window_match.sv
// Combinational test of one HSV pixel against one colour window.
// A hue window with lo > hi wraps through 0 (red).
module hsv_window_match
    import hsv_pkg::*;
(
    input  logic [H_W-1:0]  h_i,
    input  logic [SV_W-1:0] s_i,
    input  logic [SV_W-1:0] v_i,
    input  logic [H_W-1:0]  h_lo_i,
    input  logic [H_W-1:0]  h_hi_i,
    input  logic [SV_W-1:0] s_lo_i,
    input  logic [SV_W-1:0] v_lo_i,
    output logic            match_o
);

    logic hue_ok;

    // Inclusive hue range, plain or wrapping, combined with S/V minimums.
    always_comb begin
        if (h_lo_i <= h_hi_i) begin
            hue_ok = (h_i >= h_lo_i) && (h_i <= h_hi_i);
        end else begin
            hue_ok = (h_i >= h_lo_i) || (h_i <= h_hi_i);
        end
        match_o = hue_ok && (s_i >= s_lo_i) && (v_i >= v_lo_i);
    end

endmodule

// File: rtl/hsv_colour_bbox.sv
// Per-pixel colour mask plus per-frame, per-colour bounding box and
// pixel count, published as a one-cycle pulse after end of frame.
module hsv_colour_bbox
    import hsv_pkg::*;
#(
    parameter int IMAGE_W    = 640,
    parameter int IMAGE_H    = 480,
    parameter int NUM_COL    = 4,
    parameter int MIN_PIXELS = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [H_W-1:0]             hsv_h,
    input  logic [SV_W-1:0]            hsv_s,
    input  logic [SV_W-1:0]            hsv_v,
    input  logic                       valid_in,
    input  logic                       sop_in,
    input  logic                       eop_in,
    input  logic [H_W*NUM_COL-1:0]     thr_h_lo,
    input  logic [H_W*NUM_COL-1:0]     thr_h_hi,
    input  logic [SV_W*NUM_COL-1:0]    thr_s_lo,
    input  logic [SV_W*NUM_COL-1:0]    thr_v_lo,
    output logic [NUM_COL-1:0]         mask_out,
    output logic                       mask_valid,
    output logic [COORD_W*NUM_COL-1:0] x_min,
    output logic [COORD_W*NUM_COL-1:0] x_max,
    output logic [COORD_W*NUM_COL-1:0] y_min,
    output logic [COORD_W*NUM_COL-1:0] y_max,
    output logic [CNT_W*NUM_COL-1:0]   pix_count,
    output logic [NUM_COL-1:0]         found,
    output logic                       bbox_valid,
    output logic                       frame_overrun
);

    localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(IMAGE_W - 1);
    localparam logic [COORD_W-1:0] Y_END   = COORD_W'(IMAGE_H);
    localparam logic [CNT_W-1:0]   MIN_CNT = CNT_W'(MIN_PIXELS);

    state_e state_q, state_d;

    // Coordinates the next non-sop pixel will take.
    logic [COORD_W-1:0] nx_q, nx_d, ny_q, ny_d;
    logic               ovf_q, ovf_d;

    logic [COORD_W-1:0] xmin_q [NUM_COL];
    logic [COORD_W-1:0] xmin_d [NUM_COL];
    logic [COORD_W-1:0] xmax_q [NUM_COL];
    logic [COORD_W-1:0] xmax_d [NUM_COL];
    logic [COORD_W-1:0] ymin_q [NUM_COL];
    logic [COORD_W-1:0] ymin_d [NUM_COL];
    logic [COORD_W-1:0] ymax_q [NUM_COL];
    logic [COORD_W-1:0] ymax_d [NUM_COL];
    logic [CNT_W-1:0]   cnt_q  [NUM_COL];
    logic [CNT_W-1:0]   cnt_d  [NUM_COL];

    logic [NUM_COL-1:0] match;
    logic               start, accept, clear, in_range, take, publish_d;
    logic [COORD_W-1:0] cur_x, cur_y;

    logic [NUM_COL-1:0]         mask_q;
    logic                       mask_valid_q;
    logic [COORD_W*NUM_COL-1:0] x_min_q, x_max_q, y_min_q, y_max_q;
    logic [CNT_W*NUM_COL-1:0]   pix_count_q;
    logic [NUM_COL-1:0]         found_q;
    logic                       bbox_valid_q, frame_overrun_q;

    for (genvar k = 0; k < NUM_COL; k++) begin : g_win
        hsv_window_match u_win (
            .h_i    (hsv_h),
            .s_i    (hsv_s),
            .v_i    (hsv_v),
            .h_lo_i (thr_h_lo[k*H_W +: H_W]),
            .h_hi_i (thr_h_hi[k*H_W +: H_W]),
            .s_lo_i (thr_s_lo[k*SV_W +: SV_W]),
            .v_lo_i (thr_v_lo[k*SV_W +: SV_W]),
            .match_o(match[k])
        );
    end

    // Frame sequencing, coordinate tracking and accumulator next-state.
    always_comb begin
        start    = valid_in && sop_in;
        accept   = valid_in && (start || (state_q == ACTIVE));
        clear    = start || (state_q == PUBLISH);
        cur_x    = start ? '0 : nx_q;
        cur_y    = start ? '0 : ny_q;
        in_range = cur_y < Y_END;
        take     = accept && in_range;

        ovf_d = clear ? 1'b0 : ovf_q;
        if (accept && !in_range) begin
            ovf_d = 1'b1;
        end

        nx_d = clear ? '0 : nx_q;
        ny_d = clear ? '0 : ny_q;
        if (take) begin
            if (cur_x == X_LAST) begin
                nx_d = '0;
                ny_d = cur_y + 1'b1;
            end else begin
                nx_d = cur_x + 1'b1;
                ny_d = cur_y;
            end
        end

        for (int unsigned k = 0; k < NUM_COL; k++) begin
            xmin_d[k] = clear ? '1 : xmin_q[k];
            xmax_d[k] = clear ? '0 : xmax_q[k];
            ymin_d[k] = clear ? '1 : ymin_q[k];
            ymax_d[k] = clear ? '0 : ymax_q[k];
            cnt_d[k]  = clear ? '0 : cnt_q[k];
            if (take && match[k]) begin
                if (cur_x < xmin_d[k]) xmin_d[k] = cur_x;
                if (cur_x > xmax_d[k]) xmax_d[k] = cur_x;
                if (cur_y < ymin_d[k]) ymin_d[k] = cur_y;
                if (cur_y > ymax_d[k]) ymax_d[k] = cur_y;
                cnt_d[k] = sat_inc(cnt_d[k]);
            end
        end

        if (accept && eop_in) begin
            state_d = PUBLISH;
        end else if (start || (state_q == ACTIVE)) begin
            state_d = ACTIVE;
        end else begin
            state_d = IDLE;
        end
        publish_d = (state_d == PUBLISH);
    end

    // State, coordinate and accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            nx_q    <= '0;
            ny_q    <= '0;
            ovf_q   <= 1'b0;
            for (int unsigned k = 0; k < NUM_COL; k++) begin
                xmin_q[k] <= '1;
                xmax_q[k] <= '0;
                ymin_q[k] <= '1;
                ymax_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
        end else begin
            state_q <= state_d;
            nx_q    <= nx_d;
            ny_q    <= ny_d;
            ovf_q   <= ovf_d;
            for (int unsigned k = 0; k < NUM_COL; k++) begin
                xmin_q[k] <= xmin_d[k];
                xmax_q[k] <= xmax_d[k];
                ymin_q[k] <= ymin_d[k];
                ymax_q[k] <= ymax_d[k];
                cnt_q[k]  <= cnt_d[k];
            end
        end
    end

    // Registered per-pixel mask, one cycle behind the accepted pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q       <= '0;
            mask_valid_q <= 1'b0;
        end else begin
            mask_q       <= accept ? match : '0;
            mask_valid_q <= accept;
        end
    end

    // Results are captured on the edge that enters PUBLISH, from the
    // final accumulator values, so they are stable while bbox_valid is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_min_q         <= '0;
            x_max_q         <= '0;
            y_min_q         <= '0;
            y_max_q         <= '0;
            pix_count_q     <= '0;
            found_q         <= '0;
            bbox_valid_q    <= 1'b0;
            frame_overrun_q <= 1'b0;
        end else begin
            bbox_valid_q <= publish_d;
            if (publish_d) begin
                frame_overrun_q <= ovf_d;
                for (int unsigned k = 0; k < NUM_COL; k++) begin
                    pix_count_q[k*CNT_W +: CNT_W] <= cnt_d[k];
                    if (cnt_d[k] == '0) begin
                        x_min_q[k*COORD_W +: COORD_W] <= '0;
                        x_max_q[k*COORD_W +: COORD_W] <= '0;
                        y_min_q[k*COORD_W +: COORD_W] <= '0;
                        y_max_q[k*COORD_W +: COORD_W] <= '0;
                        found_q[k]                    <= 1'b0;
                    end else begin
                        x_min_q[k*COORD_W +: COORD_W] <= xmin_d[k];
                        x_max_q[k*COORD_W +: COORD_W] <= xmax_d[k];
                        y_min_q[k*COORD_W +: COORD_W] <= ymin_d[k];
                        y_max_q[k*COORD_W +: COORD_W] <= ymax_d[k];
                        found_q[k]                    <= (cnt_d[k] >= MIN_CNT);
                    end
                end
            end
        end
    end

    assign mask_out      = mask_q;
    assign mask_valid    = mask_valid_q;
    assign x_min         = x_min_q;
    assign x_max         = x_max_q;
    assign y_min         = y_min_q;
    assign y_max         = y_max_q;
    assign pix_count     = pix_count_q;
    assign found         = found_q;
    assign bbox_valid    = bbox_valid_q;
    assign frame_overrun = frame_overrun_q;

endmodule
